dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port: the target that answers requests issued by the MEM stage.
- Accepts one request per handshake and returns a full 32-bit word after a programmable number of wait states.
- Applies byte-enable writes and flags illegal accesses.
- Sits beside the core in the SoC/testbench top; byte-lane extraction and sign extension stay in the core's MEM stage.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the backing array; power of two, >= 16.
- WAIT_CYCLES, 1: extra cycles between accept and response; legal 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous reset, active high
- req_m_i  input  1  request valid from the core
- we_m_i  input  1  1 = store, 0 = load
- addr_m_i  input  32  byte address
- be_m_i  input  4  byte enables, lane 0 = bits 7:0
- wdata_m_i  input  32  store data, lane-aligned
- gnt_m_o  output  1  request accepted this cycle (combinational)
- rvalid_m_o  output  1  response valid, one-cycle pulse
- rdata_m_o  output  32  load data; 0 for stores and errors
- err_m_o  output  1  access error, valid with rvalid_m_o
- busy_o  output  1  a transaction is outstanding

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state=IDLE, gnt_m_o=1, rvalid_m_o=0, rdata_m_o=0, err_m_o=0, busy_o=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- gnt_m_o = (state==IDLE) || (state==RESP).
- A request is accepted when req_m_i && gnt_m_o. On accept, latch addr, we, be, wdata and compute err.
- Accept transitions:
  - If WAIT_CYCLES==0, go to RESP.
  - Otherwise go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; when the counter is 0, go to RESP. req_m_i is ignored (gnt=0).
- RESP: rvalid_m_o=1 for exactly this cycle.
  - If a new request is accepted in the same cycle, apply the accept rules above.
  - If not, return to IDLE.
- Throughput: one transaction per cycle when WAIT_CYCLES==0; otherwise one per WAIT_CYCLES+1 cycles.
- Latency: rvalid_m_o asserts WAIT_CYCLES+1 cycles after the accept edge.
- busy_o = (state!=IDLE).
- err conditions (any one sets err):
  - (addr-BASE_ADDR) >= DEPTH_WORDS*4
  - be not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}
  - be=0011/1100 with addr[0]!=0
  - be=1111 with addr[1:0]!=0
- On err: no array write, rdata_m_o=0, err_m_o=1.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Store: byte-enabled write committed at the end of the RESP cycle; rdata_m_o=0.
- Load: returns the full word regardless of be; be is used only for the err check.
- Array read is synchronous:
  - Read is issued on the cycle the FSM enters RESP on the next edge.
  - The array is write-first: a load hitting the address being stored in the same cycle returns the new data.
  - Back-to-back store then load to the same word with WAIT_CYCLES=0 therefore returns the stored value.
- Reset mid-transaction: the transaction is dropped, no write occurs, and no rvalid is produced. The core side must treat it as aborted.
- rdata_m_o and err_m_o are registered and hold 0 outside RESP.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE/WAIT/RESP)
  - legal byte-enable pattern constants
  - the be-legality/alignment check function, reused by the core's load/store unit assertions
- Sub-module dmem_sram_1rw (DEPTH_WORDS x 32):
  - synchronous read, byte-enable write, write-first on same-address collision
  - contents loadable via $readmemh in simulation

Test Plan:
- Reset held 3 cycles during a WAIT with WAIT_CYCLES=3 -> rvalid never asserts; gnt_m_o=1 first cycle after release; array word unchanged.
- WAIT_CYCLES=2: store 0xDEADBEEF, be=1111, addr=0x10; then load 0x10 -> gnt gaps of 2 cycles; each rvalid 3 cycles after accept; load rdata=0xDEADBEEF, err=0.
- WAIT_CYCLES=0: back-to-back store be=0010 wdata=0x0000AB00 to 0x20 (word previously 0x11223344), then load 0x20 next cycle -> rvalid on consecutive cycles; load rdata=0x1122AB44.
- Illegal accesses: addr=0x22 be=1111; addr=0x21 be=0011; be=0101; addr=BASE_ADDR+DEPTH_WORDS*4 -> each responds err=1, rdata=0, no array change.
- Streaming: 64 random legal loads/stores with req held high, WAIT_CYCLES=0 -> 64 rvalid pulses in 64 consecutive cycles; data matches the scoreboard model.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and the core's
// load/store unit checks.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned NUM_LANES = 4;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } dmem_req_t;

  // Byte-enable pattern must be a legal size and naturally aligned.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] lo);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: be_legal = 1'b1;
      BE_HLO, BE_HHI:             be_legal = (lo[0] == 1'b0);
      BE_W:                       be_legal = (lo == 2'b00);
      default:                    be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_1rw.sv
// Word-wide array: synchronous read, byte-enable write, write-first on
// read/write address collision.
module dmem_sram_1rw
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [NUM_LANES-1:0] be,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] merged;

  always_comb begin
    merged = mem[waddr];
    for (int i = 0; i < NUM_LANES; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merged;
    if (re) rdata <= (we && (raddr == waddr)) ? merged : mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the MEM stage: one request per handshake, response
// after WAIT_CYCLES wait states, byte-enable writes and access-error flagging.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_m_i,
  input  logic        we_m_i,
  input  logic [31:0] addr_m_i,
  input  logic [3:0]  be_m_i,
  input  logic [31:0] wdata_m_i,
  output logic        gnt_m_o,
  output logic        rvalid_m_o,
  output logic [31:0] rdata_m_o,
  output logic        err_m_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state, state_n;
  logic [3:0]  cnt, cnt_n;
  dmem_req_t   req_in, req_q;
  logic [AW-1:0] idx_in, idx_q, raddr;
  logic [31:0] off, sram_q;
  logic accept, enter_resp, rd_ok, rd_ok_n, err_q, err_n, sram_we;

  assign off    = addr_m_i - BASE_ADDR;
  assign idx_in = off[AW+1:2];
  assign req_in = '{we: we_m_i, be: be_m_i, wdata: wdata_m_i,
                    err: ({1'b0, off} >= SPAN) || !be_legal(be_m_i, addr_m_i[1:0])};

  assign gnt_m_o    = (state == ST_IDLE) || (state == ST_RESP);
  assign accept     = req_m_i && gnt_m_o;
  assign busy_o     = (state != ST_IDLE);
  assign rvalid_m_o = (state == ST_RESP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_n = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_n = ST_RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The read is launched on the cycle before RESP so data lands with rvalid;
  // a same-cycle accept means the new request's address is not latched yet.
  assign enter_resp = (state_n == ST_RESP);
  assign raddr      = accept ? idx_in : idx_q;
  assign rd_ok_n    = enter_resp && (accept ? !(req_in.we || req_in.err)
                                            : !(req_q.we || req_q.err));
  assign err_n      = enter_resp && (accept ? req_in.err : req_q.err);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rd_ok <= rd_ok_n;
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= req_in;
      idx_q <= idx_in;
    end
  end

  // Store commits at the end of RESP; a reset in that cycle aborts it.
  assign sram_we = (state == ST_RESP) && req_q.we && !req_q.err && !reset;

  dmem_sram_1rw #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .re    (enter_resp),
    .raddr (raddr),
    .we    (sram_we),
    .waddr (idx_q),
    .be    (req_q.be),
    .wdata (req_q.wdata),
    .rdata (sram_q)
  );

  assign rdata_m_o = rd_ok ? sram_q : 32'h0;
  assign err_m_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) share the
// request bus; each has its own req line, reference memory and response queue.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int WCS [NI] = '{0, 2, 3};
  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [NI];
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt [NI];
  logic        rvalid [NI];
  logic [31:0] rdata [NI];
  logic        err [NI];
  logic        busy [NI];

  exp_t        sbq [NI][$];
  logic [31:0] mdl [NI][DEPTH];
  int          vec = 0, miss = 0, cyc = 0;
  int          nresp [NI] = '{0, 0, 0};
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCS[g]), .BASE_ADDR(32'h0)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_m_i    (req[g]),
      .we_m_i     (we),
      .addr_m_i   (addr),
      .be_m_i     (be),
      .wdata_m_i  (wdata),
      .gnt_m_o    (gnt[g]),
      .rvalid_m_o (rvalid[g]),
      .rdata_m_o  (rdata[g]),
      .err_m_o    (err[g]),
      .busy_o     (busy[g])
    );
  end

  function automatic bit tb_legal(input logic [3:0] b, input logic [31:0] a);
    case (b)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      4'b0011, 4'b1100:                   return a[0] == 1'b0;
      4'b1111:                            return a[1:0] == 2'b00;
      default:                            return 1'b0;
    endcase
  endfunction

  // Responses are checked against the queue head, including arrival cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        if (rvalid[g]) begin
          nresp[g]++;
          vec++;
          assert (sbq[g].size() > 0) else begin
            miss++;
            $error("FAIL unexpected_rvalid inst%0d: observed rdata=%h err=%b with no request outstanding", g, rdata[g], err[g]);
          end
          if (sbq[g].size() > 0) begin
            exp_t e;
            e = sbq[g].pop_front();
            assert (rdata[g] === e.rdata && err[g] === e.err && cyc === e.cyc) else begin
              miss++;
              $error("FAIL resp inst%0d: observed rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                     g, rdata[g], err[g], cyc, e.rdata, e.err, e.cyc);
            end
          end
        end else begin
          vec++;
          assert (rdata[g] === 32'h0 && err[g] === 1'b0) else begin
            miss++;
            $error("FAIL idle_outputs inst%0d: observed rdata=%h err=%b expected 0/0", g, rdata[g], err[g]);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on instance g, wait for grant, record the expectation.
  task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit track, input bit hold);
    int n;
    exp_t e;
    int idx;
    we = w; addr = a; be = b; wdata = d; req[g] = 1'b1;
    n = 0;
    while (!gnt[g] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("gnt_wait", {31'h0, gnt[g]}, 32'h1);
    if (track) begin
      e.cyc = cyc + 1 + WCS[g];
      e.rdata = 32'h0;
      e.err = 1'b0;
      if (!tb_legal(b, a) || a >= DEPTH * 4) begin
        e.err = 1'b1;
      end else begin
        idx = int'(a[7:2]);
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (b[i]) mdl[g][idx][8*i +: 8] = d[8*i +: 8];
        end else begin
          e.rdata = mdl[g][idx];
        end
      end
      sbq[g].push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) req[g] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] bes  [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [1:0] offs [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
    int n0, k;

    reset = 1'b1;
    for (int g = 0; g < NI; g++) req[g] = 1'b0;
    we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check("reset_gnt",    {31'h0, gnt[g]},    32'h1);
      check("reset_busy",   {31'h0, busy[g]},   32'h0);
      check("reset_rvalid", {31'h0, rvalid[g]}, 32'h0);
      check("reset_rdata",  rdata[g],           32'h0);
      check("reset_err",    {31'h0, err[g]},    32'h0);
    end
    reset = 1'b0;
    mon_en = 1'b1;

    // Fill every word of the zero-wait instance, streaming.
    for (int i = 0; i < DEPTH; i++) issue(0, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1, 1'b1);
    req[0] = 1'b0;
    issue(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b1, 1'b0);
    idle_cycles(2);

    // Partial store then load of the same word on consecutive cycles.
    issue(0, 1'b1, 32'h20, 4'b0010, 32'h0000_AB00, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b1, 1'b0);
    idle_cycles(2);
    check("merged_model", mdl[0][8], 32'h1122_AB44);

    // Illegal accesses, then confirm the word is untouched.
    issue(0, 1'b1, 32'h22, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(0, 1'b1, 32'h21, 4'b0011, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(0, 1'b1, 32'h100, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b1, 1'b0);
    idle_cycles(2);

    // Random legal stream with req held high.
    n0 = nresp[0];
    for (int i = 0; i < 64; i++) begin
      k = $urandom_range(0, 6);
      issue(0, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, DEPTH - 1)), offs[k]},
            bes[k], $urandom, 1'b1, 1'b1);
    end
    req[0] = 1'b0;
    idle_cycles(3);
    check("stream_count", 32'(nresp[0] - n0), 32'd64);

    // Two-wait-state instance: grant gaps and store/load round trip.
    issue(1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("w2_gnt_gap1", {31'h0, gnt[1]},  32'h0);
    check("w2_busy",     {31'h0, busy[1]}, 32'h1);
    idle_cycles(1);
    check("w2_gnt_gap2", {31'h0, gnt[1]},  32'h0);
    idle_cycles(1);
    check("w2_gnt_resp", {31'h0, gnt[1]},  32'h1);
    issue(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0);
    idle_cycles(5);

    // Reset during a wait phase aborts the store.
    issue(2, 1'b1, 32'h30, 4'hF, 32'hA5A5_0F0F, 1'b1, 1'b0);
    idle_cycles(6);
    issue(2, 1'b1, 32'h30, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    check("w3_in_wait", {31'h0, busy[2]}, 32'h1);
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    check("rst_rel_gnt",  {31'h0, gnt[2]},  32'h1);
    check("rst_rel_busy", {31'h0, busy[2]}, 32'h0);
    idle_cycles(6);
    issue(2, 1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0);
    idle_cycles(8);

    for (int g = 0; g < NI; g++) check("queue_drained", 32'(sbq[g].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
